// File: rtl/copy_burst_gen.sv
// Splits line-granular copy commands into bursts of up to MAX_BURST_CNT lines, one burst per cycle.
// Define COPY_BURST_GEN_PAGE_SPLIT_EN to keep every burst within a 4 KB page.
module copy_burst_gen #(
   parameter int ADDR_WIDTH    = 64,
   parameter int LEN_WIDTH     = 32,
   parameter int MAX_BURST_CNT = 64,
   parameter int LINE_BYTES    = 64
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [LEN_WIDTH-1:0]  cmd_num_lines,
   output logic                  burst_valid,
   input  logic                  burst_ready,
   output logic [ADDR_WIDTH-1:0] burst_addr,
   output logic [7:0]            burst_len,
   output logic                  burst_last,
   output logic                  busy,
   output logic [31:0]           burst_count
);

   localparam int LB_SHIFT = $clog2(LINE_BYTES);
   localparam int NW       = (LEN_WIDTH > 13) ? LEN_WIDTH : 13;
   localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ADDR_WIDTH'(LINE_BYTES - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t                state_q, state_d;
   logic                  cmd_ready_q, cmd_ready_d;
   logic                  valid_q, valid_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [LEN_WIDTH-1:0]  rem_q, rem_d;
   logic [8:0]            n_q, n_d;
   logic [7:0]            len_q, len_d;
   logic                  last_q, last_d;
   logic [31:0]           count_q, count_d;

   logic [ADDR_WIDTH-1:0] nxt_addr;
   logic [LEN_WIDTH-1:0]  nxt_rem;
   logic [8:0]            nxt_n;
   logic                  load;

`ifdef COPY_BURST_GEN_PAGE_SPLIT_EN
   function automatic logic [8:0] calc_n(input logic [ADDR_WIDTH-1:0] a,
                                         input logic [LEN_WIDTH-1:0]  r);
      logic [NW-1:0] lim;
      logic [11:0]   off;
      logic [12:0]   pg;
      lim = NW'(MAX_BURST_CNT);
      if (NW'(r) < lim) lim = NW'(r);
      off = 12'(a);
      pg  = (13'd4096 - {1'b0, off}) >> LB_SHIFT;
      if (NW'(pg) < lim) lim = NW'(pg);
      return lim[8:0];
   endfunction
`else
   function automatic logic [8:0] calc_n(input logic [LEN_WIDTH-1:0] r);
      logic [NW-1:0] lim;
      lim = NW'(MAX_BURST_CNT);
      if (NW'(r) < lim) lim = NW'(r);
      return lim[8:0];
   endfunction
`endif

   always_comb begin
      state_d     = state_q;
      cmd_ready_d = cmd_ready_q;
      valid_d     = valid_q;
      addr_d      = addr_q;
      rem_d       = rem_q;
      n_d         = n_q;
      len_d       = len_q;
      last_d      = last_q;
      count_d     = count_q;
      nxt_addr    = addr_q;
      nxt_rem     = rem_q;
      load        = 1'b0;

      case (state_q)
         IDLE: begin
            cmd_ready_d = 1'b1;
            valid_d     = 1'b0;
            // zero-line commands are consumed here without leaving IDLE
            if (cmd_valid && cmd_ready_q && (cmd_num_lines != '0)) begin
               nxt_addr    = cmd_addr & ~LINE_MASK;
               nxt_rem     = cmd_num_lines;
               load        = 1'b1;
               state_d     = RUN;
               cmd_ready_d = 1'b0;
            end
         end
         RUN: begin
            if (valid_q && burst_ready) begin
               count_d = count_q + 32'd1;
               if (last_q) begin
                  state_d     = IDLE;
                  valid_d     = 1'b0;
                  last_d      = 1'b0;
                  cmd_ready_d = 1'b1;
               end else begin
                  nxt_addr = addr_q + (ADDR_WIDTH'(n_q) << LB_SHIFT);
                  nxt_rem  = rem_q - LEN_WIDTH'(n_q);
                  load     = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

`ifdef COPY_BURST_GEN_PAGE_SPLIT_EN
      nxt_n = calc_n(nxt_addr, nxt_rem);
`else
      nxt_n = calc_n(nxt_rem);
`endif

      if (load) begin
         addr_d  = nxt_addr;
         rem_d   = nxt_rem;
         n_d     = nxt_n;
         len_d   = 8'(nxt_n - 9'd1);
         last_d  = (NW'(nxt_n) == NW'(nxt_rem));
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         cmd_ready_q <= 1'b0;
         valid_q     <= 1'b0;
         addr_q      <= '0;
         rem_q       <= '0;
         n_q         <= '0;
         len_q       <= '0;
         last_q      <= 1'b0;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         cmd_ready_q <= cmd_ready_d;
         valid_q     <= valid_d;
         addr_q      <= addr_d;
         rem_q       <= rem_d;
         n_q         <= n_d;
         len_q       <= len_d;
         last_q      <= last_d;
         count_q     <= count_d;
      end
   end

   assign cmd_ready   = cmd_ready_q;
   assign burst_valid = valid_q;
   assign burst_addr  = addr_q;
   assign burst_len   = len_q;
   assign burst_last  = last_q;
   assign busy        = (state_q == RUN);
   assign burst_count = count_q;

endmodule

// File: tb/tb_copy_burst_gen.sv
// Directed bench for copy_burst_gen: command table with expected burst lists, plus stall and reset sequences.
module tb_copy_burst_gen;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [63:0] cmd_addr;
   logic [31:0] cmd_num_lines;
   logic        burst_valid;
   logic        burst_ready;
   logic [63:0] burst_addr;
   logic [7:0]  burst_len;
   logic        burst_last;
   logic        busy;
   logic [31:0] burst_count;

   always #5 clk = ~clk;

   copy_burst_gen dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_addr      (cmd_addr),
      .cmd_num_lines (cmd_num_lines),
      .burst_valid   (burst_valid),
      .burst_ready   (burst_ready),
      .burst_addr    (burst_addr),
      .burst_len     (burst_len),
      .burst_last    (burst_last),
      .busy          (busy),
      .burst_count   (burst_count)
   );

   typedef struct {
      logic [63:0] addr;
      logic [31:0] lines;
      int          first;
   } cmd_t;

   typedef struct {
      logic [63:0] addr;
      logic [7:0]  len;
      logic        last;
   } bst_t;

   cmd_t        cmds[$];
   bst_t        exp_b[$];
   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] exp_count = '0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic add_cmd(input logic [63:0] a, input logic [31:0] l);
      cmd_t c;
      c.addr  = a;
      c.lines = l;
      c.first = exp_b.size();
      cmds.push_back(c);
   endtask

   task automatic add_b(input logic [63:0] a, input logic [7:0] len, input logic last);
      bst_t b;
      b.addr = a;
      b.len  = len;
      b.last = last;
      exp_b.push_back(b);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [63:0] a, input logic [31:0] l);
      int t = 0;
      while (!cmd_ready && t < 50) begin
         step();
         t++;
      end
      chk("cmd_ready_wait", cmd_ready, 1);
      cmd_valid     = 1'b1;
      cmd_addr      = a;
      cmd_num_lines = l;
      step();
      cmd_valid     = 1'b0;
   endtask

   task automatic run_bursts(input int first);
      int idx  = first;
      bit done = 0;
      while (!done && idx < exp_b.size()) begin
         chk("burst_valid", burst_valid, 1);
         chk("burst_addr", burst_addr, exp_b[idx].addr);
         chk("burst_len", 64'(burst_len), 64'(exp_b[idx].len));
         chk("burst_last", burst_last, exp_b[idx].last);
         chk("cmd_ready_run", cmd_ready, 0);
         done = exp_b[idx].last;
         idx++;
         exp_count++;
         step();
      end
      chk("busy_after", busy, 0);
      chk("cmd_ready_after", cmd_ready, 1);
      chk("valid_after", burst_valid, 0);
      chk("burst_count", 64'(burst_count), 64'(exp_count));
   endtask

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      reset_n       = 1'b0;
      cmd_valid     = 1'b0;
      cmd_addr      = '0;
      cmd_num_lines = '0;
      burst_ready   = 1'b1;

      // table: commands and their expected bursts
      add_cmd(64'h40, 1);     add_b(64'h40, 0, 1);
      add_cmd(64'h1000, 10);  add_b(64'h1000, 9, 1);
      add_cmd(64'h0F80, 200);
`ifdef COPY_BURST_GEN_PAGE_SPLIT_EN
      add_b(64'h0F80, 1, 0);  add_b(64'h1000, 63, 0); add_b(64'h2000, 63, 0);
      add_b(64'h3000, 63, 0); add_b(64'h4000, 5, 1);
`else
      add_b(64'h0F80, 63, 0); add_b(64'h1F80, 63, 0); add_b(64'h2F80, 63, 0);
      add_b(64'h3F80, 7, 1);
`endif
      add_cmd(64'h0FC0, 3);
`ifdef COPY_BURST_GEN_PAGE_SPLIT_EN
      add_b(64'h0FC0, 0, 0);  add_b(64'h1000, 1, 1);
`else
      add_b(64'h0FC0, 2, 1);
`endif
      add_cmd(64'h2021, 64);  add_b(64'h2000, 63, 1);
      add_cmd(64'hFFFF_FFFF_FFFF_FFC0, 2);
`ifdef COPY_BURST_GEN_PAGE_SPLIT_EN
      add_b(64'hFFFF_FFFF_FFFF_FFC0, 0, 0); add_b(64'h0, 0, 1);
`else
      add_b(64'hFFFF_FFFF_FFFF_FFC0, 1, 1);
`endif
      add_cmd(64'h0, 129);
      add_b(64'h0, 63, 0);    add_b(64'h1000, 63, 0); add_b(64'h2000, 0, 1);
      // post-reset command, used after the mid-command reset
      add_cmd(64'h0, 64);     add_b(64'h0, 63, 1);

      // reset state
      #12;
      chk("rst_valid", burst_valid, 0);
      chk("rst_last", burst_last, 0);
      chk("rst_addr", burst_addr, 0);
      chk("rst_len", 64'(burst_len), 0);
      chk("rst_count", 64'(burst_count), 0);
      chk("rst_busy", busy, 0);
      chk("rst_cmd_ready", cmd_ready, 0);
      step();
      reset_n = 1'b1;
      chk("rel_cmd_ready_before_edge", cmd_ready, 0);
      step();
      chk("rel_cmd_ready_first_edge", cmd_ready, 1);

      // zero-line command is dropped
      issue(64'h80, 0);
      chk("zero_cmd_ready", cmd_ready, 1);
      chk("zero_valid", burst_valid, 0);
      chk("zero_busy", busy, 0);
      step();
      chk("zero_valid_2", burst_valid, 0);
      chk("zero_count", 64'(burst_count), 0);

      for (int i = 0; i < 7; i++) begin
         issue(cmds[i].addr, cmds[i].lines);
         run_bursts(cmds[i].first);
      end

      // stall the first burst for 5 cycles
      burst_ready = 1'b0;
      issue(cmds[2].addr, cmds[2].lines);
      for (int k = 0; k < 5; k++) begin
         chk("stall_valid", burst_valid, 1);
         chk("stall_addr", burst_addr, exp_b[cmds[2].first].addr);
         chk("stall_len", 64'(burst_len), 64'(exp_b[cmds[2].first].len));
         chk("stall_last", burst_last, exp_b[cmds[2].first].last);
         chk("stall_cmd_ready", cmd_ready, 0);
         chk("stall_count", 64'(burst_count), 64'(exp_count));
         step();
      end
      burst_ready = 1'b1;
      run_bursts(cmds[2].first);

      // reset during the second of four bursts
      issue(64'h0, 256);
      chk("mid_b1_addr", burst_addr, 64'h0);
      chk("mid_b1_len", 64'(burst_len), 63);
      step();
      chk("mid_b2_addr", burst_addr, 64'h1000);
      chk("mid_b2_valid", burst_valid, 1);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_valid", burst_valid, 0);
      chk("mid_rst_count", 64'(burst_count), 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_cmd_ready", cmd_ready, 0);
      chk("mid_rst_addr", burst_addr, 0);
      exp_count = '0;
      step();
      step();
      reset_n = 1'b1;
      chk("mid_rel_valid", burst_valid, 0);
      step();
      chk("mid_rel_valid_2", burst_valid, 0);
      chk("mid_rel_cmd_ready", cmd_ready, 1);
      issue(cmds[7].addr, cmds[7].lines);
      run_bursts(cmds[7].first);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
